// File: rtl/ysyx_22041211_lsu_hs.sv
// ysyx_22041211_lsu_hs
// Handshaked load/store unit between EXU and WBU. Accepts one instruction at a
// time, issues at most one request on a variable-latency memory bus, performs
// byte-lane alignment, sign/zero extension and misalignment detection, then
// presents the result to writeback.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           EXU handshake; inputs latched on accept
//   wd_i, wreg_i, alu_result_i,   instruction fields (alu_result_i is the
//   mem_wdata_i, load_type_i,     effective address for memory ops)
//   store_type_i, csr_wdata_i
//   mem_req_*                     memory request channel (valid/ready)
//   mem_rsp_*                     memory response (single-cycle valid)
//   out_valid / out_ready         WBU handshake
//   wd_o, wreg_o, wdata_o,        writeback fields, stable while out_valid
//   csr_wdata_o, memory_inst_o,
//   err_o                         0 ok, 1 load misaligned, 2 store misaligned,
//                                 3 bus error
module ysyx_22041211_lsu_hs #(
  parameter  int DATA_LEN = 32,
  parameter  int ADDR_LEN = 32,
  localparam int STRB_W   = DATA_LEN / 8,
  localparam int OFF_W    = $clog2(STRB_W)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [2:0]          load_type_i,
  input  logic [1:0]          store_type_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_req_wen,
  output logic [ADDR_LEN-1:0] mem_req_addr,
  output logic [DATA_LEN-1:0] mem_req_wdata,
  output logic [STRB_W-1:0]   mem_req_wstrb,
  input  logic                mem_rsp_valid,
  input  logic [DATA_LEN-1:0] mem_rsp_rdata,
  input  logic                mem_rsp_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                memory_inst_o,
  output logic [1:0]          err_o
);

  typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_e;

  state_e              state_q;
  logic                wd_q;
  logic [4:0]          wreg_q;
  logic [DATA_LEN-1:0] alu_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [DATA_LEN-1:0] csr_q;
  logic [DATA_LEN-1:0] rdata_q;
  logic [2:0]          load_q;
  logic [1:0]          store_q;
  logic [1:0]          err_q;

  // log2 of the access size in bytes. A nonzero load type wins over a store.
  function automatic logic [1:0] size_log(input logic [2:0] lt, input logic [1:0] st);
    logic [1:0] r;
    r = 2'd0;
    if (lt != 3'd0) begin
      case (lt)
        3'd1, 3'd2: r = 2'd0;
        3'd3, 3'd4: r = 2'd1;
        3'd5, 3'd6: r = 2'd2;
        default:    r = 2'd3;
      endcase
    end else begin
      case (st)
        2'd1:    r = 2'd0;
        2'd2:    r = 2'd1;
        default: r = (DATA_LEN == 64) ? 2'd3 : 2'd2;
      endcase
    end
    return r;
  endfunction

  function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] sz);
    logic [STRB_W-1:0] m;
    case (sz)
      2'd0:    m = STRB_W'(1);
      2'd1:    m = STRB_W'(3);
      2'd2:    m = STRB_W'(15);
      default: m = STRB_W'(255);
    endcase
    return m;
  endfunction

  // Accept-time decode of the incoming instruction.
  logic [1:0] in_size;
  logic       in_is_mem;
  logic       in_misal;
  logic [1:0] err_d;

  // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
  always_comb begin
    in_size   = size_log(load_type_i, store_type_i);
    in_is_mem = (load_type_i != 3'd0) || (store_type_i != 2'd0);
    in_misal  = in_is_mem &&
                ((4'(alu_result_i[OFF_W-1:0]) & ((4'd1 << in_size) - 4'd1)) != 4'd0);
    err_d     = 2'd0;
    if (in_misal) err_d = (load_type_i != 3'd0) ? 2'd1 : 2'd2;
  end

  // Decode of the held instruction; all derived from registers so the bus
  // fields stay stable for as long as the request is outstanding.
  logic                held_load;
  logic                held_store;
  logic [1:0]          held_size;
  logic [OFF_W-1:0]    off;
  logic [ADDR_LEN-1:0] full_addr;
  logic [DATA_LEN-1:0] shifted;
  logic [DATA_LEN-1:0] load_ext;

  always_comb begin
    held_load  = (load_q != 3'd0);
    held_store = !held_load && (store_q != 2'd0);
    held_size  = size_log(load_q, store_q);
    off        = alu_q[OFF_W-1:0];
    full_addr  = ADDR_LEN'(alu_q);
    shifted    = rdata_q >> {off, 3'b000};
    case (load_q)
      3'd1:    load_ext = DATA_LEN'(signed'(shifted[7:0]));
      3'd2:    load_ext = DATA_LEN'(shifted[7:0]);
      3'd3:    load_ext = DATA_LEN'(signed'(shifted[15:0]));
      3'd4:    load_ext = DATA_LEN'(shifted[15:0]);
      3'd5:    load_ext = DATA_LEN'(signed'(shifted[31:0]));
      3'd6:    load_ext = DATA_LEN'(shifted[31:0]);
      default: load_ext = shifted;
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_wen   = held_store;
  assign mem_req_addr  = {full_addr[ADDR_LEN-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_req_wdata = wdata_q << {off, 3'b000};
  assign mem_req_wstrb = size_mask(held_size) << off;

  assign out_valid     = (state_q == DONE);
  assign wd_o          = wd_q && (err_q == 2'd0);
  assign wreg_o        = wreg_q;
  assign wdata_o       = held_load ? load_ext : alu_q;
  assign csr_wdata_o   = csr_q;
  assign memory_inst_o = (load_q != 3'd0) || (store_q != 2'd0);
  assign err_o         = err_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wd_q    <= 1'b0;
      wreg_q  <= '0;
      alu_q   <= '0;
      wdata_q <= '0;
      csr_q   <= '0;
      rdata_q <= '0;
      load_q  <= '0;
      store_q <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Stray responses arriving here are simply not sampled.
          if (in_valid) begin
            wd_q    <= wd_i;
            wreg_q  <= wreg_i;
            alu_q   <= alu_result_i;
            wdata_q <= mem_wdata_i;
            csr_q   <= csr_wdata_i;
            load_q  <= load_type_i;
            store_q <= store_type_i;
            rdata_q <= '0;
            err_q   <= err_d;
            state_q <= (!in_is_mem || in_misal) ? DONE : REQ;
          end
        end
        REQ: begin
          // Stores also go through RSP to wait for their write-ack.
          if (mem_req_ready) state_q <= RSP;
        end
        RSP: begin
          if (mem_rsp_valid) begin
            rdata_q <= mem_rsp_rdata;
            if (mem_rsp_err) err_q <= 2'd3;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041211_lsu_hs.sv
// Directed self-checking bench for ysyx_22041211_lsu_hs (DATA_LEN=32).
module tb_ysyx_22041211_lsu_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        wd_i;
  logic [4:0]  wreg_i;
  logic [31:0] alu_result_i;
  logic [31:0] mem_wdata_i;
  logic [2:0]  load_type_i;
  logic [1:0]  store_type_i;
  logic [31:0] csr_wdata_i;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_req_wen;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  logic        mem_rsp_err;
  logic        out_valid;
  logic        out_ready;
  logic        wd_o;
  logic [4:0]  wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] csr_wdata_o;
  logic        memory_inst_o;
  logic [1:0]  err_o;

  int total  = 0;
  int passed = 0;

  ysyx_22041211_lsu_hs #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .wd_i(wd_i), .wreg_i(wreg_i), .alu_result_i(alu_result_i),
    .mem_wdata_i(mem_wdata_i), .load_type_i(load_type_i),
    .store_type_i(store_type_i), .csr_wdata_i(csr_wdata_i),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_wen(mem_req_wen), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
    .mem_rsp_err(mem_rsp_err),
    .out_valid(out_valid), .out_ready(out_ready),
    .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .csr_wdata_o(csr_wdata_o), .memory_inst_o(memory_inst_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] addr, input logic [2:0] lt, input logic [1:0] st,
                         input logic [31:0] wdat, input logic wd);
    in_valid     = 1'b1;
    alu_result_i = addr;
    load_type_i  = lt;
    store_type_i = st;
    mem_wdata_i  = wdat;
    wd_i         = wd;
    wreg_i       = 5'd7;
    csr_wdata_i  = 32'hC5C5_0001;
  endtask

  // Full load transaction with a zero-wait bus.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] lt,
                         input logic [31:0] rdata, input logic rerr,
                         input logic [31:0] exp_data, input logic [1:0] exp_err);
    present(addr, lt, 2'd0, 32'h0, 1'b1);
    step();
    in_valid = 1'b0;
    check({tag, " req_valid"}, 64'(mem_req_valid), 64'd1);
    check({tag, " req_wen"}, 64'(mem_req_wen), 64'd0);
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check({tag, " wait_rsp"}, 64'(out_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = rdata;
    mem_rsp_err   = rerr;
    step();
    mem_rsp_valid = 1'b0;
    mem_rsp_err   = 1'b0;
    check({tag, " out_valid"}, 64'(out_valid), 64'd1);
    check({tag, " err"}, 64'(err_o), 64'(exp_err));
    check({tag, " wd"}, 64'(wd_o), (exp_err == 2'd0) ? 64'd1 : 64'd0);
    if (exp_err == 2'd0) check({tag, " wdata"}, 64'(wdata_o), 64'(exp_data));
    step();
    check({tag, " back_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; wd_i = 1'b0; wreg_i = '0; alu_result_i = '0;
    mem_wdata_i = '0; load_type_i = '0; store_type_i = '0; csr_wdata_i = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
    out_ready = 1'b1;
    #1;
    step();
    step();
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst req_valid", 64'(mem_req_valid), 64'd0);
    check("rst err", 64'(err_o), 64'd0);
    check("rst wd", 64'(wd_o), 64'd0);
    rst = 1'b0;
    step();

    // ALU pass-through
    present(32'h0000_1234, 3'd0, 2'd0, 32'h0, 1'b1);
    wreg_i = 5'd5;
    step();
    in_valid = 1'b0;
    check("alu out_valid", 64'(out_valid), 64'd1);
    check("alu wdata", 64'(wdata_o), 64'h1234);
    check("alu wd", 64'(wd_o), 64'd1);
    check("alu wreg", 64'(wreg_o), 64'd5);
    check("alu csr", 64'(csr_wdata_o), 64'hC5C5_0001);
    check("alu mem_inst", 64'(memory_inst_o), 64'd0);
    check("alu no_req", 64'(mem_req_valid), 64'd0);
    check("alu in_ready", 64'(in_ready), 64'd0);
    step();
    check("alu out_drop", 64'(out_valid), 64'd0);
    check("alu no_req2", 64'(mem_req_valid), 64'd0);

    // SB at 0x8000_0003 with mem_req_ready low for 3 cycles
    present(32'h8000_0003, 3'd0, 2'd1, 32'h0000_00AB, 1'b0);
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("sb req_valid", 64'(mem_req_valid), 64'd1);
      check("sb addr", 64'(mem_req_addr), 64'h8000_0000);
      check("sb wstrb", 64'(mem_req_wstrb), 64'b1000);
      check("sb wdata", 64'(mem_req_wdata), 64'hAB00_0000);
      check("sb wen", 64'(mem_req_wen), 64'd1);
      step();
    end
    mem_req_ready = 1'b1;
    check("sb still_req", 64'(mem_req_valid), 64'd1);
    step();
    mem_req_ready = 1'b0;
    check("sb req_drop", 64'(mem_req_valid), 64'd0);
    step();
    check("sb wait_ack", 64'(out_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    step();
    mem_rsp_valid = 1'b0;
    check("sb out_valid", 64'(out_valid), 64'd1);
    check("sb err", 64'(err_o), 64'd0);
    check("sb mem_inst", 64'(memory_inst_o), 64'd1);
    step();

    // Load extension cases
    do_load("lb", 32'h8000_0002, 3'd1, 32'h0080_0000, 1'b0, 32'hFFFF_FF80, 2'd0);
    do_load("lbu", 32'h8000_0002, 3'd2, 32'h0080_0000, 1'b0, 32'h0000_0080, 2'd0);
    do_load("lh", 32'h8000_0002, 3'd3, 32'h8001_0000, 1'b0, 32'hFFFF_8001, 2'd0);
    do_load("lhu", 32'h8000_0000, 3'd4, 32'hABCD_F00D, 1'b0, 32'h0000_F00D, 2'd0);
    do_load("lw", 32'h8000_0004, 3'd5, 32'h1234_5678, 1'b0, 32'h1234_5678, 2'd0);

    // Misaligned LW / SH
    present(32'h8000_0002, 3'd5, 2'd0, 32'h0, 1'b1);
    step();
    in_valid = 1'b0;
    check("lw_mis no_req", 64'(mem_req_valid), 64'd0);
    check("lw_mis out_valid", 64'(out_valid), 64'd1);
    check("lw_mis err", 64'(err_o), 64'd1);
    check("lw_mis wd", 64'(wd_o), 64'd0);
    step();
    present(32'h8000_0001, 3'd0, 2'd2, 32'h0, 1'b1);
    step();
    in_valid = 1'b0;
    check("sh_mis no_req", 64'(mem_req_valid), 64'd0);
    check("sh_mis err", 64'(err_o), 64'd2);
    check("sh_mis wd", 64'(wd_o), 64'd0);
    step();

    // Output backpressure: outputs held, no new accept
    out_ready = 1'b0;
    present(32'h0000_9999, 3'd0, 2'd0, 32'h0, 1'b1);
    step();
    present(32'h0000_5555, 3'd0, 2'd0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check("bp out_valid", 64'(out_valid), 64'd1);
      check("bp wdata", 64'(wdata_o), 64'h9999);
      check("bp in_ready", 64'(in_ready), 64'd0);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp last_hold", 64'(wdata_o), 64'h9999);
    step();
    check("bp out_drop", 64'(out_valid), 64'd0);
    check("bp in_ready2", 64'(in_ready), 64'd1);

    // Bus error
    do_load("buserr", 32'h8000_0008, 3'd5, 32'h0, 1'b1, 32'h0, 2'd3);

    // Reset while waiting in RSP, then a stray response
    present(32'h8000_000C, 3'd5, 2'd0, 32'h0, 1'b1);
    step();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    check("rsprst in_rsp", 64'(in_ready), 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rsprst in_ready", 64'(in_ready), 64'd1);
    check("rsprst req_valid", 64'(mem_req_valid), 64'd0);
    check("rsprst out_valid", 64'(out_valid), 64'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_rdata = 32'hDEAD_BEEF;
    step();
    mem_rsp_valid = 1'b0;
    check("stray out_valid", 64'(out_valid), 64'd0);
    check("stray in_ready", 64'(in_ready), 64'd1);
    step();
    check("stray out_valid2", 64'(out_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_lsu_hs.md
Name: ysyx_22041211_lsu_hs

Overview:
Handshaked, parametrised load/store unit that sits between the EXU and the WBU. It replaces fixed-timing memory access with valid/ready on both the pipeline and the memory sides. It accepts one instruction at a time and issues at most one request on a variable-latency memory bus. It performs byte-lane alignment, sign/zero extension and misalignment detection, then hands the result to writeback.

Parameters:
DATA_LEN, 32, data width in bits; supported values are 32 and 64 (byte lanes = DATA_LEN/8)
ADDR_LEN, 32, address width in bits
OFF_W, $clog2(DATA_LEN/8), byte-offset bits within a data word (derived)

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
in_valid  input  1  EXU presents an instruction
in_ready  output  1  LSU can accept an instruction
wd_i  input  1  register write enable
wreg_i  input  5  destination register index
alu_result_i  input  DATA_LEN  effective address, or the writeback value for non-memory ops
mem_wdata_i  input  DATA_LEN  store data, right-aligned
load_type_i  input  3  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWU, 7 LD; 6 and 7 only when DATA_LEN=64
store_type_i  input  2  0 none, 1 SB, 2 SH, 3 SW (SD when DATA_LEN=64)
csr_wdata_i  input  DATA_LEN  CSR write value, passed through
mem_req_valid  output  1  memory request valid
mem_req_ready  input  1  memory accepts request
mem_req_wen  output  1  1 for store, 0 for load
mem_req_addr  output  ADDR_LEN  word-aligned address (low OFF_W bits zero)
mem_req_wdata  output  DATA_LEN  lane-shifted store data
mem_req_wstrb  output  DATA_LEN/8  byte strobes; loads drive the read strobes
mem_rsp_valid  input  1  response valid (single cycle)
mem_rsp_rdata  input  DATA_LEN  raw word read
mem_rsp_err  input  1  bus error
out_valid  output  1  result valid to WBU
out_ready  input  1  WBU accepts result
wd_o  output  1  register write enable (forced 0 on any error)
wreg_o  output  5  destination register
wdata_o  output  DATA_LEN  writeback data
csr_wdata_o  output  DATA_LEN  CSR data
memory_inst_o  output  1  the held instruction is a load or a store
err_o  output  2  0 ok, 1 load misaligned, 2 store misaligned, 3 bus error; valid with out_valid

Behaviour:
- Reset: state IDLE; in_ready=1; out_valid=0; mem_req_valid=0; err_o=0; wd_o=0; all holding registers 0. A reset mid-transaction drops the transaction. Any late mem_rsp_valid is ignored while in IDLE.
- States: IDLE, REQ, RSP, DONE. in_ready = (state==IDLE).
- Accept: when in_valid && in_ready, latch all inputs.
  - Non-memory op, or misaligned access → DONE next cycle.
  - Otherwise → REQ.
- Misaligned: an access of size S whose address is not divisible by S. No memory request is issued. err_o is 1 for a load or 2 for a store. If both load_type and store_type are nonzero, the load takes priority.
- REQ: mem_req_valid=1, with all request fields stable until mem_req_ready. On mem_req_valid && mem_req_ready: a load → RSP; a store → RSP. A store still waits for its write-ack mem_rsp_valid.
- RSP: on mem_rsp_valid, latch rdata and err, then → DONE. mem_rsp_valid in the same cycle as the request handshake is not legal for the bus and is not sampled.
- DONE: out_valid=1 and outputs stable until out_ready; then → IDLE. Minimum latencies with out_ready held high:
  - non-memory op: 2 cycles from accept to out_valid deassert.
  - memory op with zero-wait bus: REQ → RSP → DONE, so out_valid rises in the 3rd cycle after accept.
- Lane rules (off = addr[OFF_W-1:0]):
  - wstrb = size-mask << off.
  - wdata = mem_wdata_i << (8*off).
  - Read: shifted = rdata >> (8*off). Then LB/LH/LW sign-extend from bit 7/15/31; LBU/LHU/LWU zero-extend; LD passes through.
- wdata_o: loads give the extended read data; all other ops give the latched alu_result_i.
- On any error, wd_o=0.

Test Plan:
- ALU pass-through: in alu_result_i=0x1234, wd_i=1, wreg_i=5, load/store none, out_ready=1 → out_valid exactly 1 cycle after accept; wdata_o=0x1234; no mem_req_valid ever.
- SB at 0x8000_0003, data 0xAB → mem_req_addr=0x8000_0000, wstrb=4'b1000, wdata=0xAB000000. With mem_req_ready held low 3 cycles, the request stays stable; after the ack, out_valid with err_o=0.
- LB at offset 2, rsp 0x0080_0000 → wdata_o=0xFFFF_FF80. Same access as LBU → 0x0000_0080. LH at offset 2, rsp 0x8001_0000 → 0xFFFF_8001.
- LW at 0x8000_0002 → no mem_req_valid; out_valid next cycle; err_o=1, wd_o=0. SH at 0x...1 → err_o=2.
- Backpressure: out_ready low 4 cycles in DONE → outputs held, in_ready=0, a new in_valid is not accepted. Bus error: mem_rsp_err=1 → err_o=3, wd_o=0.
- Reset asserted in RSP → next cycle IDLE, in_ready=1, mem_req_valid=0. A subsequent stray mem_rsp_valid → no out_valid.
